sll_16b8i: RTL and testbench

Registered 16-bit logical shift-left unit for the processor ALU datapath. Shifts operand `a` left by the amount in operand `b`, filling vacated low bits with zeros. Result is captured in an output register one clock after a valid request. It sits beside the adder and logic units and feeds the ALU result mux.

---
 rtl/sll16_pkg.sv | 16 +
 rtl/sll16_stage.sv | 27 ++
 rtl/sll_16b8i.sv | 82 ++++++++
 tb/tb_sll_16b8i.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sll16_pkg.sv
// Shared types and constants for the 16-bit shift-left unit.
// Optional feature macro used by this slice: SLL16_SHOUT_EN (lost-bit flag).
package sll16_pkg;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned SHAMT_W = 4;

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

  // Any set bit above the in-range shift field pushes every operand bit out.
  function automatic logic is_out_of_range(input word_t amount);
    return |amount[WIDTH-1:SHAMT_W];
  endfunction

endpackage : sll16_pkg

// File: rtl/sll16_stage.sv
// One conditional fixed-distance left shift of the barrel shifter.
// With SLL16_SHOUT_EN it also reports whether a set bit fell off the top.
module sll16_stage
  import sll16_pkg::*;
#(
  parameter int unsigned DIST = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_data
`ifdef SLL16_SHOUT_EN
  , output logic           o_lost
`endif
);

  word_t w_shifted;

  assign w_shifted = {i_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
  assign o_data    = i_en ? w_shifted : i_data;

`ifdef SLL16_SHOUT_EN
  // Bits lost here are original operand bits, so OR-ing every stage's loss
  // gives exactly the bits of a that leave bit 15.
  assign o_lost = i_en & (|i_data[WIDTH-1 -: DIST]);
`endif

endmodule : sll16_stage

// File: rtl/sll_16b8i.sv
// Registered 16-bit logical shift-left: 4-stage log shifter, out-of-range zeroing,
// one-cycle latency. Define SLL16_SHOUT_EN to add the registered shout flag.
module sll_16b8i
  import sll16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             out_valid
`ifdef SLL16_SHOUT_EN
  , output logic           shout
`endif
);

  shamt_t w_shamt;
  logic   w_oor;
  word_t  w_stage [0:SHAMT_W];
  word_t  w_result;

  word_t  r_result;
  logic   r_valid;

  assign w_shamt    = b[SHAMT_W-1:0];
  assign w_oor      = is_out_of_range(b);
  assign w_stage[0] = a;

`ifdef SLL16_SHOUT_EN
  logic [SHAMT_W-1:0] w_lost;
  logic               w_shout;
  logic               r_shout;
`endif

  // Stage k shifts by 2**k when shift-amount bit k is set.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    sll16_stage #(
      .DIST (1 << k)
    ) u_stage (
      .i_data (w_stage[k]),
      .i_en   (w_shamt[k]),
      .o_data (w_stage[k+1])
`ifdef SLL16_SHOUT_EN
      , .o_lost (w_lost[k])
`endif
    );
  end

  assign w_result = w_oor ? '0 : w_stage[SHAMT_W];

`ifdef SLL16_SHOUT_EN
  assign w_shout = w_oor ? (|a) : (|w_lost);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and wins over in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_valid  <= 1'b0;
`ifdef SLL16_SHOUT_EN
      r_shout  <= 1'b0;
`endif
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_result;
`ifdef SLL16_SHOUT_EN
        r_shout  <= w_shout;
`endif
      end
    end
  end

  assign r         = r_result;
  assign out_valid = r_valid;
`ifdef SLL16_SHOUT_EN
  assign shout     = r_shout;
`endif

endmodule : sll_16b8i

// File: tb/tb_sll_16b8i.sv
// Self-checking bench for sll_16b8i: directed cases then randomized traffic
// compared against an arithmetic reference model.
module tb_sll_16b8i;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] r;
  logic        out_valid;
`ifdef SLL16_SHOUT_EN
  logic        shout;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_r;
  logic        exp_valid;
  logic        exp_shout;

  sll_16b8i dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .r         (r),
    .out_valid (out_valid)
`ifdef SLL16_SHOUT_EN
    , .shout   (shout)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: shift in a 32-bit field; the upper half holds the lost bits.
  task automatic model_step(input logic rst, input logic v, input logic [15:0] ma, input logic [15:0] mb);
    logic [31:0] full;
    full = {16'h0000, ma} << mb;
    if (!rst) begin
      exp_r     = 16'h0000;
      exp_valid = 1'b0;
      exp_shout = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        if (mb >= 16) begin
          exp_r     = 16'h0000;
          exp_shout = (ma != 16'h0000);
        end else begin
          exp_r     = full[15:0];
          exp_shout = (full[31:16] != 16'h0000);
        end
      end
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [15:0] ta, input logic [15:0] tbv);
    @(negedge clk);
    rst_n    = rst;
    in_valid = v;
    a        = ta;
    b        = tbv;
    model_step(rst, v, ta, tbv);
    @(posedge clk);
    #1;
    check($sformatf("r rst_n=%0b v=%0b a=%h b=%h", rst, v, ta, tbv), {16'h0, r}, {16'h0, exp_r});
    check($sformatf("out_valid rst_n=%0b v=%0b a=%h b=%h", rst, v, ta, tbv), {31'h0, out_valid}, {31'h0, exp_valid});
`ifdef SLL16_SHOUT_EN
    check($sformatf("shout rst_n=%0b v=%0b a=%h b=%h", rst, v, ta, tbv), {31'h0, shout}, {31'h0, exp_shout});
`endif
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rv;
    logic        rr;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    exp_r     = '0;
    exp_valid = 1'b0;
    exp_shout = 1'b0;

    // Reset state
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);

    // Walking shift amounts, back-to-back
    for (int i = 0; i <= 4; i++) drive(1'b1, 1'b1, 16'h0001, 16'(i));

    // Boundary patterns
    drive(1'b1, 1'b1, 16'hFFFF, 16'd15);
    drive(1'b1, 1'b1, 16'h00FF, 16'd8);
    drive(1'b1, 1'b1, 16'h1234, 16'd16);
    drive(1'b1, 1'b1, 16'h1234, 16'hFFFF);
    drive(1'b1, 1'b1, 16'hBEEF, 16'd0);
    drive(1'b1, 1'b1, 16'h0000, 16'd20);

    // Reset collides with a request, then idle
    drive(1'b1, 1'b1, 16'h00F0, 16'd4);
    drive(1'b0, 1'b1, 16'h0003, 16'd2);
    drive(1'b1, 1'b0, 16'h0003, 16'd2);

    // Hold while idle
    drive(1'b1, 1'b1, 16'h0005, 16'd1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'($urandom), 16'($urandom));

    // Randomized traffic with occasional resets and wide shift amounts
    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'($urandom);
        1:       rb = 16'($urandom_range(14, 18));
        default: rb = 16'($urandom_range(0, 15));
      endcase
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 39) != 0);
      drive(rr, rv, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sll_16b8i
